systolic_mac_array: RTL and testbench
=====================================

# systolic_mac_array

Output-stationary N×N multiply-accumulate array that consumes the skewed, zero-padded row/column streams produced by the matrix-to-systolic indexing stage. The block computes C = A·B, where A enters on the west edge and B enters on the north edge. It holds one C element per processing element (PE) and drains the finished matrix one row per handshake to the downstream result buffer.

## Interface
Parameters:
- N, 4: array dimension; 2 ≤ N ≤ 32.
- DW, 8: signed operand width.
- AW, 32: signed accumulator and result width.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a pass; honoured only in IDLE.
- in_valid  in  1  skewed beat present on a_in and b_in.
- a_in  in  N*DW  west-edge lanes; lane i is a_in[i*DW +: DW] and feeds row i.
- b_in  in  N*DW  north-edge lanes; lane j is b_in[j*DW +: DW] and feeds column j.
- in_ready  out  1  high in FEED.
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  high in DRAIN.
- out_ready  in  1  downstream accepts out_row.
- out_row  out  N*AW  row r of C; column j is out_row[j*AW +: AW].
- out_idx  out  5  row index r of out_row.
- done  out  1  one-cycle pulse after the last row is accepted.

## Operation
States: IDLE → FEED → FLUSH → DRAIN → IDLE.

- **IDLE**
  - When start = 1: clear every accumulator and every a/b pipe register, clear the counters, and enter FEED on the next cycle.
- **FEED**
  - A step occurs only on a beat (in_valid && in_ready).
  - Exactly FEED_BEATS = 2N−1 beats are accepted, then the block enters FLUSH.
  - When in_valid = 0, the array holds its state.
- **FLUSH**
  - One step per cycle for FLUSH_STEPS = N−1 cycles, with zero injected on all edge lanes.
  - Then the block enters DRAIN with r = 0.
- **DRAIN**
  - out_row = acc row r and out_idx = r.
  - On out_valid && out_ready, r increments.
  - When r = N−1 is accepted, the block enters IDLE and pulses done.

PE(i,j) behaviour on each step:
- The west operand aw is a_in lane i when j = 0, otherwise a_reg of PE(i,j−1).
- The north operand bn is b_in lane j when i = 0, otherwise b_reg of PE(i−1,j).
- Update: acc ← acc + sext(aw·bn); a_reg ← aw; b_reg ← bn.
- Consequence: operand k meets PE(i,j) at step i+j+k, and a pass totals 3N−2 steps.

Arithmetic and width rules:
- The product is a 2·DW-bit signed value, sign-extended to AW.
- Accumulation wraps modulo 2^AW, with no saturation.

Boundary conditions:
- start outside IDLE is ignored.
- A beat offered when in_ready = 0 is not consumed.
- Holding out_ready = 0 stalls DRAIN indefinitely; out_row is stable while stalled.
- clr has priority over everything. At any point mid-operation it returns all state to reset values on the next edge, and any partial pass is discarded.
- start asserted in the same cycle as clr is ignored.

## Timing
- Reset values: in_ready, busy, out_valid and done = 0; out_idx = 0; out_row = 0; all accumulators and pipe registers = 0.
- start sampled in cycle 0: busy and in_ready are 1 from cycle 1.
- With in_valid held at 1:
  - Beats are accepted in cycles 1 to 2N−1.
  - FLUSH occupies cycles 2N to 3N−2.
  - out_valid rises in cycle 3N−1.
- With out_ready held at 1:
  - Rows are presented in cycles 3N−1 to 4N−2.
  - done = 1 and busy = 0 in cycle 4N−1.
- Total latency from start to done is 4N−1 cycles with no stalls; N = 4 gives 15.
- out_row is registered directly from the accumulators, adding no extra cycle. It changes only on a handshake or a state entry.

## Structure
- Package systolic_pkg holds:
  - the defaults for N, DW and AW;
  - the state enum {IDLE, FEED, FLUSH, DRAIN};
  - constant functions for FEED_BEATS(N) = 2N−1 and FLUSH_STEPS(N) = N−1;
  - the 5-bit index type shared with the indexing stage.
- Sub-module systolic_pe contains one PE:
  - registers a_reg, b_reg and acc;
  - inputs step and clear;
  - it is instantiated N×N with a generate loop.
- The top level holds the FSM, the beat/step/row counters and the output row mux.

## Test plan
- **Identity:** N=4, A = I, B = [[1..4],[5..8],[9..12],[13..16]] skewed with zero padding → rows 0 to 3 equal B; done arrives 15 cycles after start.
- **All-ones:** A = B = all 1 → every element equals 4; the values 8 on out_row and 127 on out_idx never appear.
- **Input stalls:** toggle in_valid in a 1-on/2-off pattern during FEED → C identical to the unstalled run; in_ready stays high throughout FEED.
- **Backpressure:** out_ready = 0 for 5 cycles at row 1 → out_row and out_idx = 1 held stable; rows are delivered in order 0, 1, 2, 3 exactly once.
- **Signed extremes:** A = B = all −128 → every element equals 65536. With AW=16, every element wraps to 0.
- **clr and start:**
  - clr asserted in the 3rd FEED beat → all outputs return to zero on the next cycle.
  - start pulsed during DRAIN → ignored; the current pass completes unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic MAC array.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  // Row/element index shared with the matrix-to-systolic indexing stage.
  typedef logic [4:0] idx_t;

  function automatic int feed_beats(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int flush_steps(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards a east and b south, accumulates a*b.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 clear,
  input  logic                 step,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);

  logic signed [DW-1:0]   r_a;
  logic signed [DW-1:0]   r_b;
  logic signed [AW-1:0]   r_acc;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_prod_ext;

  assign w_prod     = a_in * b_in;
  // Signed size cast sign-extends; the sum below wraps modulo 2^AW.
  assign w_prod_ext = AW'(w_prod);

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (step) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign a_out = r_a;
  assign b_out = r_b;
  assign acc   = r_acc;

endmodule

// File: rtl/systolic_mac_array.sv
// N x N output-stationary MAC array: feeds 2N-1 skewed beats, flushes N-1 steps,
// then drains C one row per handshake; FEED stalls on in_valid, DRAIN stalls on out_ready.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          in_valid,
  input  logic [N*DW-1:0] a_in,
  input  logic [N*DW-1:0] b_in,
  output logic          in_ready,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*AW-1:0] out_row,
  output logic [4:0]    out_idx,
  output logic          done
);

  localparam logic [6:0] LAST_BEAT  = 7'(feed_beats(N) - 1);
  localparam logic [5:0] LAST_FLUSH = 6'(flush_steps(N) - 1);
  localparam idx_t       LAST_ROW   = idx_t'(N - 1);

  state_t     r_state;
  logic [6:0] r_beat;
  logic [5:0] r_flush;
  idx_t       r_row;
  logic       r_done;

  logic w_beat;
  logic w_step;
  logic w_clear;

  logic signed [DW-1:0] w_a_w [N][N];
  logic signed [DW-1:0] w_b_n [N][N];
  logic signed [DW-1:0] w_a_o [N][N];
  logic signed [DW-1:0] w_b_o [N][N];
  logic signed [AW-1:0] w_acc [N][N];
  logic [N*AW-1:0]      w_row;
  logic                 w_unused_edge;

  assign w_beat  = (r_state == FEED) && in_valid;
  assign w_step  = w_beat || (r_state == FLUSH);
  assign w_clear = (r_state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FEED;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
          end
        end
        FEED: begin
          if (in_valid) begin
            if (r_beat == LAST_BEAT) begin
              r_state <= FLUSH;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + 7'd1;
            end
          end
        end
        FLUSH: begin
          if (r_flush == LAST_FLUSH) begin
            r_state <= DRAIN;
            r_flush <= '0;
            r_row   <= '0;
          end else begin
            r_flush <= r_flush + 6'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_row == LAST_ROW) begin
              r_state <= IDLE;
              r_row   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_row <= r_row + 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Edge lanes only carry data in FEED; FLUSH pushes zeros through the array.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_west
        assign w_a_w[gi][gj] = (r_state == FEED) ? a_in[gi*DW +: DW] : '0;
      end else begin : g_inner_a
        assign w_a_w[gi][gj] = w_a_o[gi][gj-1];
      end
      if (gi == 0) begin : g_north
        assign w_b_n[gi][gj] = (r_state == FEED) ? b_in[gj*DW +: DW] : '0;
      end else begin : g_inner_b
        assign w_b_n[gi][gj] = w_b_o[gi-1][gj];
      end

      systolic_pe #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk   (clk),
        .clr   (clr),
        .clear (w_clear),
        .step  (w_step),
        .a_in  (w_a_w[gi][gj]),
        .b_in  (w_b_n[gi][gj]),
        .a_out (w_a_o[gi][gj]),
        .b_out (w_b_o[gi][gj]),
        .acc   (w_acc[gi][gj])
      );
    end
  end

  // Accumulators are frozen in DRAIN, so the row only moves on a handshake or state entry.
  always_comb begin
    w_row = '0;
    if (r_state == DRAIN) begin
      for (int i = 0; i < N; i++) begin
        if (r_row == idx_t'(i)) begin
          for (int j = 0; j < N; j++) begin
            w_row[j*AW +: AW] = w_acc[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    w_unused_edge = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_unused_edge = w_unused_edge ^ (^w_a_o[i][N-1]) ^ (^w_b_o[N-1][i]);
    end
  end

  assign in_ready  = (r_state == FEED);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DRAIN);
  assign out_row   = w_row;
  assign out_idx   = r_row;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array (N=4, DW=8, AW=32 plus an AW=16 wrap instance).
module tb_systolic_mac_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clr, start, in_valid, out_ready;
  logic [N*DW-1:0] a_in, b_in;
  logic            in_ready, busy, out_valid, done;
  logic [N*AW-1:0] out_row;
  logic [4:0]      out_idx;
  logic            in_ready16, busy16, out_valid16, done16;
  logic [N*16-1:0] out_row16;
  logic [4:0]      out_idx16;

  systolic_mac_array #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(in_ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .done(done)
  );

  systolic_mac_array #(.N(N), .DW(DW), .AW(16)) dut16 (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(in_ready16), .busy(busy16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
    .out_idx(out_idx16), .done(done16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int t0   = 0;
  bit chk16 = 1'b0;

  logic signed [7:0]  A [N][N];
  logic signed [7:0]  B [N][N];
  logic signed [31:0] E [N][N];
  logic signed [15:0] E16 [N][N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exprow(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*32 +: 32] = E[r][j];
    return v;
  endfunction

  function automatic logic [127:0] exprow16(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*16 +: 16] = E16[r][j];
    return v;
  endfunction

  // Skewed, zero-padded beat t: lane i carries A[i][t-i], lane j carries B[t-j][j].
  task automatic set_beat(input int t);
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - i;
      a_in[i*DW +: DW] = (k >= 0 && k < N) ? A[i][k] : 8'sd0;
      b_in[i*DW +: DW] = (k >= 0 && k < N) ? B[k][i] : 8'sd0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
  endtask

  task automatic feed(input bit stall);
    for (int t = 0; t < 2*N-1; t++) begin
      set_beat(t);
      in_valid = 1'b1;
      chk("in_ready_beat", in_ready, 1);
      tick();
      if (stall && t < 2*N-2) begin
        in_valid = 1'b0;
        a_in = {N{8'h7f}};
        b_in = {N{8'h81}};
        repeat (2) begin
          chk("in_ready_stall", in_ready, 1);
          tick();
        end
      end
    end
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
  endtask

  task automatic drain(input bit check_lat, input int bp_row, input int start_row);
    int waitc;
    waitc = 0;
    while (!out_valid && waitc < 40) begin
      tick();
      waitc++;
    end
    chk("out_valid_rise", out_valid, 1);
    if (check_lat) chk("valid_cycle", cyc - t0 + 1, 3*N-1);
    for (int r = 0; r < N; r++) begin
      chk("row_valid", out_valid, 1);
      chk("row_idx", out_idx, r);
      chk("row_data", out_row, exprow(r));
      if (chk16) chk("row_data16", out_row16, exprow16(r));
      if (r == bp_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("bp_valid", out_valid, 1);
          chk("bp_idx", out_idx, r);
          chk("bp_data", out_row, exprow(r));
        end
        out_ready = 1'b1;
      end
      if (r == start_row) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    if (check_lat) chk("done_cycle", cyc - t0 + 1, 4*N-1);
    tick();
    chk("done_drop", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 8'sd1 : 8'sd0;
        B[i][j] = 8'(i*N + j + 1);
        E[i][j] = 32'(i*N + j + 1);
      end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0;
    tick(); tick();
    clr = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_row", out_row, 0);

    // Identity A: C equals B, 15-cycle latency.
    load_identity();
    do_start();
    feed(1'b0);
    drain(1'b1, -1, -1);

    // All ones: every element 4.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 8'sd1; B[i][j] = 8'sd1; E[i][j] = 32'sd4;
      end
    do_start();
    feed(1'b0);
    drain(1'b1, -1, -1);

    // Identity with 1-on/2-off input stalls.
    load_identity();
    do_start();
    feed(1'b1);
    drain(1'b0, -1, -1);

    // B*B with backpressure at row 1.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 8'(i*N + j + 1);
        B[i][j] = 8'(i*N + j + 1);
      end
    E = '{'{32'sd90,  32'sd100, 32'sd110, 32'sd120},
          '{32'sd202, 32'sd228, 32'sd254, 32'sd280},
          '{32'sd314, 32'sd356, 32'sd398, 32'sd440},
          '{32'sd426, 32'sd484, 32'sd542, 32'sd600}};
    do_start();
    feed(1'b0);
    drain(1'b0, 1, -1);

    // Signed extremes: 4 * 16384 = 65536, which wraps to 0 in 16 bits.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = -8'sd128; B[i][j] = -8'sd128;
        E[i][j] = 32'sd65536; E16[i][j] = 16'sd0;
      end
    chk16 = 1'b1;
    do_start();
    feed(1'b0);
    drain(1'b1, -1, -1);
    chk16 = 1'b0;

    // clr on the third FEED beat discards the pass.
    load_identity();
    do_start();
    set_beat(0); in_valid = 1'b1; tick();
    set_beat(1); tick();
    set_beat(2); clr = 1'b1; tick();
    clr = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    chk("clr_in_ready", in_ready, 0);
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_done", done, 0);
    chk("clr_out_idx", out_idx, 0);
    chk("clr_out_row", out_row, 0);

    // start together with clr is ignored.
    clr = 1'b1; start = 1'b1; tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", busy, 0);
    tick();
    chk("clr_start_busy2", busy, 0);

    // start pulsed during DRAIN is ignored; pass completes unchanged.
    do_start();
    feed(1'b0);
    drain(1'b1, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
